// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of loader, control, instruction-memory and IF/ID signals for imem_fetch_ctrl.
// The slave modport is the controller's view; master is the view of whatever surrounds it.
interface imem_fetch_ctrl_if;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;

  logic        run_start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;

  logic [31:0] im_addr;
  logic        im_we;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;

  logic [31:0] if_id_ir;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [1:0]  state;
  logic        fault;

  modport slave (
    input  ld_start, ld_valid, ld_addr, ld_data, ld_last,
    input  run_start, stall, redirect, redirect_pc, halt_req,
    input  im_rdata,
    output ld_ready, im_addr, im_we, im_wdata,
    output if_id_ir, if_id_pc4, if_id_valid, state, fault
  );

  modport master (
    output ld_start, ld_valid, ld_addr, ld_data, ld_last,
    output run_start, stall, redirect, redirect_pc, halt_req,
    output im_rdata,
    input  ld_ready, im_addr, im_we, im_wdata,
    input  if_id_ir, if_id_pc4, if_id_valid, state, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Owns the instruction-memory port: loads a program through the loader handshake,
// then runs the fetch stage (PC, IF/ID register, stall, redirect, halt, fault).
module imem_fetch_ctrl #(
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifIdIr_q, ifIdIr_d;
  logic [31:0] ifIdPc4_q, ifIdPc4_d;
  logic        ifIdValid_q, ifIdValid_d;
  logic        fault_q, fault_d;

  logic        loadWrite;
  logic        redirectMisaligned;
  logic        fetchOutOfRange;

  assign loadWrite          = (state_q == ST_LOAD) && bus.ld_valid;
  assign redirectMisaligned = (bus.redirect_pc[1:0] != 2'b00);
  assign fetchOutOfRange    = (pc_q[31:2] >= WORD_LIMIT);

  // The memory port belongs to the loader only while a load word is being written.
  assign bus.ld_ready = (state_q == ST_LOAD);
  assign bus.im_we    = loadWrite;
  assign bus.im_addr  = loadWrite ? {23'd0, bus.ld_addr, 2'b00} : pc_q;
  assign bus.im_wdata = loadWrite ? bus.ld_data : 32'd0;

  assign bus.if_id_ir    = ifIdIr_q;
  assign bus.if_id_pc4   = ifIdPc4_q;
  assign bus.if_id_valid = ifIdValid_q;
  assign bus.state       = state_q;
  assign bus.fault       = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ifIdIr_q    <= 32'd0;
      ifIdPc4_q   <= 32'd0;
      ifIdValid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifIdIr_q    <= ifIdIr_d;
      ifIdPc4_q   <= ifIdPc4_d;
      ifIdValid_q <= ifIdValid_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifIdIr_d    = ifIdIr_q;
    ifIdPc4_d   = ifIdPc4_q;
    ifIdValid_d = ifIdValid_q;
    fault_d     = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ld_start) begin
          state_d = ST_LOAD;
        end else if (bus.run_start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end

      ST_LOAD: begin
        if (bus.ld_valid && bus.ld_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Halt beats redirect, which beats the range check, which beats stall.
        if (bus.halt_req) begin
          state_d     = ST_HALT;
          ifIdValid_d = 1'b0;
          ifIdIr_d    = 32'd0;
        end else if (bus.redirect && redirectMisaligned) begin
          state_d     = ST_HALT;
          fault_d     = 1'b1;
          ifIdValid_d = 1'b0;
          ifIdIr_d    = 32'd0;
        end else if (bus.redirect) begin
          pc_d        = bus.redirect_pc;
          ifIdValid_d = 1'b0;
          ifIdIr_d    = 32'd0;
        end else if (fetchOutOfRange) begin
          state_d     = ST_HALT;
          fault_d     = 1'b1;
          ifIdValid_d = 1'b0;
          ifIdIr_d    = 32'd0;
        end else if (!bus.stall) begin
          ifIdIr_d    = bus.im_rdata;
          ifIdPc4_d   = pc_q + 32'd4;
          ifIdValid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end

      ST_HALT: begin
        ifIdValid_d = 1'b0;
        if (bus.ld_start) begin
          state_d = ST_LOAD;
          fault_d = 1'b0;
          pc_d    = RESET_PC;
        end else if (bus.run_start) begin
          state_d = ST_RUN;
          fault_d = 1'b0;
          pc_d    = RESET_PC;
        end
      end
    endcase
  end

  // IF/ID only ever carries a real instruction while fetching.
  assert property (@(posedge clk) disable iff (rst) ifIdValid_q |-> (state_q == ST_RUN));
  assert property (@(posedge clk) disable iff (rst) bus.im_we |-> bus.ld_ready);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized scoreboard bench for imem_fetch_ctrl with a transaction-level model
// of program memory, PC and fetch stream; a negedge monitor checks IF/ID contents.
module tb_imem_fetch_ctrl;
  localparam int WORDS = 128;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus();

  imem_fetch_ctrl #(.IMEM_WORDS(WORDS), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: synchronous write, combinational read.
  logic [31:0] mem [0:WORDS-1];
  always @(posedge clk) begin
    if (bus.im_we) mem[bus.im_addr[8:2]] <= bus.im_wdata;
  end
  assign bus.im_rdata = (bus.im_addr[31:9] == 23'd0) ? mem[bus.im_addr[8:2]] : 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
  } fetch_t;

  logic [31:0] refMem [0:WORDS-1];
  int          modelState;
  logic [31:0] modelPc;
  logic        modelFault;
  logic        pushedEdge;
  logic        holdEdge;
  logic        bubbleEdge;
  fetch_t      expQ[$];
  fetch_t      lastExp;
  int          checks;
  int          passes;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  // Each edge the model has just processed either pushed a fetch, held IF/ID, or neither.
  always @(negedge clk) begin
    if (!rst) begin
      if (pushedEdge) begin
        checkOutput("fetch_valid", 32'(bus.if_id_valid), 32'd1);
        if (expQ.size() != 0) begin
          lastExp = expQ.pop_front();
          checkOutput("fetch_ir", bus.if_id_ir, lastExp.ir);
          checkOutput("fetch_pc4", bus.if_id_pc4, lastExp.pc4);
        end
      end else if (bus.if_id_valid === 1'b1) begin
        if (holdEdge) begin
          checkOutput("hold_ir", bus.if_id_ir, lastExp.ir);
          checkOutput("hold_pc4", bus.if_id_pc4, lastExp.pc4);
        end else begin
          checks++;
          $display("[TB] FAIL unexpected_fetch: got ir %h pc4 %h expected no valid", bus.if_id_ir, bus.if_id_pc4);
        end
      end
    end
  end

  task automatic applyStimulus(input logic ldStart, input logic ldValid, input logic [6:0] ldAddr,
                               input logic [31:0] ldData, input logic ldLast, input logic runStart,
                               input logic stallIn, input logic redirectIn, input logic [31:0] redirectPc,
                               input logic haltReq);
    fetch_t f;
    logic   writing;
    bus.ld_start    = ldStart;
    bus.ld_valid    = ldValid;
    bus.ld_addr     = ldAddr;
    bus.ld_data     = ldData;
    bus.ld_last     = ldLast;
    bus.run_start   = runStart;
    bus.stall       = stallIn;
    bus.redirect    = redirectIn;
    bus.redirect_pc = redirectPc;
    bus.halt_req    = haltReq;
    #1;
    writing = (modelState == 1) && ldValid;
    checkOutput("ld_ready", 32'(bus.ld_ready), 32'(modelState == 1));
    checkOutput("im_we", 32'(bus.im_we), 32'(writing));
    checkOutput("im_addr", bus.im_addr, writing ? {23'd0, ldAddr, 2'b00} : modelPc);
    if (writing) checkOutput("im_wdata", bus.im_wdata, ldData);
    @(posedge clk);
    pushedEdge = 1'b0;
    holdEdge   = 1'b0;
    bubbleEdge = 1'b0;
    case (modelState)
      0: begin
        if (ldStart) modelState = 1;
        else if (runStart) begin modelState = 2; modelPc = 32'h0; end
      end
      1: begin
        if (ldValid) begin
          refMem[ldAddr] = ldData;
          if (ldLast) modelState = 0;
        end
      end
      2: begin
        if (haltReq) begin
          modelState = 3; bubbleEdge = 1'b1;
        end else if (redirectIn && redirectPc[1:0] != 2'b00) begin
          modelState = 3; modelFault = 1'b1; bubbleEdge = 1'b1;
        end else if (redirectIn) begin
          modelPc = redirectPc; bubbleEdge = 1'b1;
        end else if ((modelPc >> 2) >= 32'(WORDS)) begin
          modelState = 3; modelFault = 1'b1; bubbleEdge = 1'b1;
        end else if (stallIn) begin
          holdEdge = 1'b1;
        end else begin
          f.ir  = refMem[modelPc[8:2]];
          f.pc4 = modelPc + 32'd4;
          expQ.push_back(f);
          pushedEdge = 1'b1;
          modelPc = modelPc + 32'd4;
        end
      end
      default: begin
        if (ldStart) begin modelState = 1; modelFault = 1'b0; modelPc = 32'h0; end
        else if (runStart) begin modelState = 2; modelFault = 1'b0; modelPc = 32'h0; end
      end
    endcase
    #1;
    checkOutput("state", 32'(bus.state), 32'(modelState));
    checkOutput("fault", 32'(bus.fault), 32'(modelFault));
    if (bubbleEdge) begin
      checkOutput("bubble_valid", 32'(bus.if_id_valid), 32'd0);
      checkOutput("bubble_ir", bus.if_id_ir, 32'd0);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic startLoad();
    applyStimulus(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic startRun();
    applyStimulus(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic loadWord(input logic [6:0] addr, input logic [31:0] data, input logic last);
    applyStimulus(1'b0, 1'b1, addr, data, last, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic runCycle(input logic st, input logic rd, input logic [31:0] rpc, input logic hr);
    applyStimulus(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, st, rd, rpc, hr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] savedPc;
    logic [6:0]  tgt;
    int          r;
    checks = 0; passes = 0;
    modelState = 0; modelPc = 32'h0; modelFault = 1'b0;
    pushedEdge = 1'b0; holdEdge = 1'b0; bubbleEdge = 1'b0;
    lastExp = '0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = 7'd0; bus.ld_data = 32'd0;
    bus.ld_last = 1'b0; bus.run_start = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0; bus.halt_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_valid", 32'(bus.if_id_valid), 32'd0);
    checkOutput("rst_ir", bus.if_id_ir, 32'd0);
    checkOutput("rst_pc4", bus.if_id_pc4, 32'd0);
    checkOutput("rst_fault", 32'(bus.fault), 32'd0);
    checkOutput("rst_im_addr", bus.im_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-word program, then fetch it and halt.
    startLoad();
    loadWord(7'd0, 32'h00222820, 1'b0);
    loadWord(7'd1, 32'h20610006, 1'b0);
    loadWord(7'd2, 32'h00823022, 1'b1);
    startRun();
    repeat (3) runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    runCycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Fill the rest of memory with random words.
    startLoad();
    for (int i = 3; i < WORDS; i++) loadWord(7'(i), $urandom, i == WORDS - 1);

    // Stall at pc=8, then redirect to 0x10 while stalled.
    startRun();
    repeat (2) runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) runCycle(1'b1, 1'b0, 32'd0, 1'b0);
    runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    runCycle(1'b1, 1'b1, 32'h10, 1'b0);
    runCycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Random mix of fetch, stall and aligned redirects kept inside memory.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      tgt = 7'($urandom_range(0, WORDS - 1));
      if (modelPc >= 32'd480 || r == 9) runCycle(1'($urandom_range(0, 1)), 1'b1, {23'd0, tgt, 2'b00}, 1'b0);
      else if (r >= 7) runCycle(1'b1, 1'b0, 32'd0, 1'b0);
      else runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    end

    // Halt and redirect together: halt wins and pc is not updated.
    savedPc = modelPc;
    runCycle(1'b0, 1'b1, 32'h40, 1'b1);
    #1;
    checkOutput("halt_pc_frozen", bus.im_addr, savedPc);

    // Misaligned redirect faults; run_start clears it.
    startRun();
    repeat (2) runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    runCycle(1'b0, 1'b1, 32'h6, 1'b0);
    idleCycle();
    startRun();

    // Sequential fetch to the end of memory faults at pc=512.
    for (int k = 0; k < 200 && modelState == 2 && modelPc < 32'd512; k++) runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("end_pc", modelPc, 32'd512);
    runCycle(1'b0, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a load after two of four words.
    startLoad();
    loadWord(7'd10, 32'hA5A50010, 1'b0);
    loadWord(7'd11, 32'h5A5A0011, 1'b0);
    bus.ld_valid = 1'b1; bus.ld_addr = 7'd12; bus.ld_data = 32'hFFFF0012;
    #2;
    rst = 1'b1;
    #1;
    modelState = 0; modelPc = 32'h0; modelFault = 1'b0;
    pushedEdge = 1'b0; holdEdge = 1'b0; bubbleEdge = 1'b0;
    checkOutput("midload_state", 32'(bus.state), 32'd0);
    checkOutput("midload_valid", 32'(bus.if_id_valid), 32'd0);
    checkOutput("midload_ir", bus.if_id_ir, 32'd0);
    checkOutput("midload_pc4", bus.if_id_pc4, 32'd0);
    checkOutput("midload_ld_ready", 32'(bus.ld_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    startRun();
    runCycle(1'b0, 1'b1, 32'h28, 1'b0);
    repeat (3) runCycle(1'b0, 1'b0, 32'd0, 1'b0);
    runCycle(1'b0, 1'b0, 32'd0, 1'b1);
    idleCycle();

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
